// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PrID storage, M-stage interrupt/exception
// evaluation and the combinational IntReq pipeline flush request.
module cp0_unit #(
    parameter logic [31:0] PRID = 32'h2021_0B0A
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] M_PC_i,
    input  logic        M_BD_i,
    input  logic [4:0]  ExcCode_i,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC_o,
    output logic [31:0] DOut
);

    logic [5:0]  im_q, im_d, ip_q, ip_d;
    logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] epc_tgt;
    logic        int_req, exc_req;

    // Interrupts look at live HWInt so the flush happens in the same cycle.
    assign int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
    assign exc_req = (ExcCode_i != 5'd0) & ~exl_q;
    assign IntReq  = int_req | exc_req;
    assign EPC_o   = epc_q;
    assign epc_tgt = M_BD_i ? (M_PC_i - 32'd4) : M_PC_i;

    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        exc_d = exc_q;
        epc_d = epc_q;
        ip_d  = HWInt;
        if (IntReq) begin
            // Event entry overrides both eret and any mtc0 in the same cycle.
            exl_d = 1'b1;
            bd_d  = M_BD_i;
            exc_d = int_req ? 5'd0 : ExcCode_i;
            epc_d = {epc_tgt[31:2], 2'b00};
        end else begin
            if (EXLClr) exl_d = 1'b0;
            if (WE) begin
                case (A2)
                    5'd12: begin
                        im_d  = DIn[15:10];
                        exl_d = DIn[1];
                        ie_d  = DIn[0];
                    end
                    5'd14:   epc_d = {DIn[31:2], 2'b00};
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= '0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            ip_q  <= ip_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    always_comb begin
        DOut = '0;
        case (A1)
            5'd12:   DOut = {16'd0, im_q, 8'd0, exl_q, ie_q};
            5'd13:   DOut = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'd0};
            5'd14:   DOut = epc_q;
            5'd15:   DOut = PRID;
            default: DOut = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: expectations are queued as stimulus is
// applied and popped when the corresponding DUT output is sampled.
`timescale 1ns/100ps
module tb_cp0_unit;

    localparam logic [31:0] PRID = 32'h2021_0B0A;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1, A2, ExcCode_i;
    logic [31:0] DIn, M_PC_i;
    logic        WE, M_BD_i, EXLClr;
    logic [5:0]  HWInt;
    logic        IntReq;
    logic [31:0] EPC_o, DOut;

    cp0_unit #(.PRID(PRID)) dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
        .M_PC_i(M_PC_i), .M_BD_i(M_BD_i), .ExcCode_i(ExcCode_i),
        .HWInt(HWInt), .EXLClr(EXLClr), .IntReq(IntReq), .EPC_o(EPC_o),
        .DOut(DOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", got, 32'hxxxx_xxxx);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, got, e.val);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        sb_push(tag, exp);
        A1 = a;
        #0.5;
        sb_pop(DOut);
    endtask

    task automatic irq(input string tag, input logic exp);
        sb_push(tag, {31'd0, exp});
        #0.2;
        sb_pop({31'd0, IntReq});
    endtask

    task automatic epc(input string tag, input logic [31:0] exp);
        sb_push(tag, exp);
        #0.2;
        sb_pop(EPC_o);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        A2 = a; DIn = d; WE = 1'b1;
        cyc();
        WE = 1'b0;
    endtask

    initial begin
        reset = 1'b1; A1 = '0; A2 = '0; DIn = '0; WE = 1'b0; M_PC_i = '0;
        M_BD_i = 1'b0; ExcCode_i = '0; HWInt = '0; EXLClr = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        rd("rst_sr", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc", 5'd14, 32'h0);
        rd("rst_prid", 5'd15, PRID);
        rd("rst_other", 5'd3, 32'h0);
        irq("rst_intreq", 1'b0);
        epc("rst_epc_o", 32'h0);

        // Masked interrupt still lands in Cause.IP, no request
        HWInt = 6'b100000;
        irq("masked_intreq", 1'b0);
        cyc();
        HWInt = '0;
        rd("masked_ip", 5'd13, 32'h0000_8000);
        cyc();
        rd("ip_cleared", 5'd13, 32'h0);

        // Interrupt; SR write has unused bits that must be dropped
        mtc0(5'd12, 32'hFFFF_0001 & 32'h0000_FFFF | 32'h0000_0400 | 32'h0000_00F0);
        rd("sr_write", 5'd12, 32'h0000_0401);
        HWInt = 6'b000001; M_PC_i = 32'h3010; M_BD_i = 1'b0;
        irq("int_req", 1'b1);
        cyc();
        rd("int_sr", 5'd12, 32'h0000_0403);
        rd("int_cause", 5'd13, 32'h0000_0400);
        rd("int_epc", 5'd14, 32'h3010);
        irq("int_nested", 1'b0);

        // eret while interrupt still pending
        EXLClr = 1'b1;
        irq("eret_cycle_irq", 1'b0);
        epc("eret_cycle_epc", 32'h3010);
        cyc();
        EXLClr = 1'b0;
        rd("eret_sr", 5'd12, 32'h0000_0401);
        irq("eret_reirq", 1'b1);

        // Interrupt + exception + mtc0 EPC in one cycle
        ExcCode_i = 5'd4; M_PC_i = 32'h3206;
        A2 = 5'd14; DIn = 32'h1234; WE = 1'b1;
        irq("prio_irq", 1'b1);
        epc("prio_old_epc", 32'h3010);
        cyc();
        WE = 1'b0; ExcCode_i = '0; HWInt = '0;
        rd("prio_cause", 5'd13, 32'h0000_0400);
        rd("prio_epc", 5'd14, 32'h3204);

        // mtc0 SR=0 also clears EXL; Cause is read-only
        mtc0(5'd12, 32'h0);
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd("cause_ro", 5'd13, 32'h0);

        // Exception in delay slot with IE=0
        ExcCode_i = 5'd12; M_PC_i = 32'h3024; M_BD_i = 1'b1;
        irq("exc_req", 1'b1);
        cyc();
        irq("exc_nested", 1'b0);
        ExcCode_i = '0; M_BD_i = 1'b0;
        rd("exc_cause", 5'd13, 32'h8000_0030);
        rd("exc_epc", 5'd14, 32'h3020);
        rd("exc_sr", 5'd12, 32'h0000_0002);

        // mtc0 EPC: alignment and no read bypass
        A2 = 5'd14; DIn = 32'h3043; WE = 1'b1;
        rd("raw_old", 5'd14, 32'h3020);
        cyc();
        WE = 1'b0;
        rd("raw_new", 5'd14, 32'h3040);

        // Async reset mid-handler, between edges
        #1 reset = 1'b1;
        rd("arst_sr", 5'd12, 32'h0);
        rd("arst_cause", 5'd13, 32'h0);
        rd("arst_epc", 5'd14, 32'h0);
        epc("arst_epc_o", 32'h0);
        ExcCode_i = 5'd8;
        #0.1 reset = 1'b1;
        irq("arst_irq_live", 1'b1);
        ExcCode_i = '0;
        irq("arst_irq", 1'b0);
        cyc();
        reset = 1'b0;

        if (sb_q.size() != 0) check("sb_leftover", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
